// File: rtl/stall_ctrl.sv
// stall_ctrl: pipeline stall/flush controller for the five-stage core.
// Converts busy/hazard/flush requests into per-stage register enables and
// bubble clears, sequences deferred and discarding flushes through a small
// FSM, and keeps saturating stall/flush performance counters.
`ifndef W_DATA
`define W_DATA 32
`endif

module stall_ctrl (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_id,
  input  logic               if_busy,
  input  logic               ex_busy,
  input  logic               mm_busy,
  input  logic               flush_req,
  input  logic [`W_DATA-1:0] flush_pc,
  output logic               en_pc,
  output logic               en_id,
  output logic               en_ex,
  output logic               en_mm,
  output logic               en_wb,
  output logic               clr_id,
  output logic               clr_ex,
  output logic               clr_mm,
  output logic               clr_wb,
  output logic               redirect_valid,
  output logic [`W_DATA-1:0] redirect_pc,
  output logic [31:0]        perf_stall,
  output logic [15:0]        perf_flush
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    FLUSH_WAIT = 2'd1,
    DISCARD    = 2'd2
  } state_t;

  state_t             state;
  logic [`W_DATA-1:0] target_q;
  logic               apply;     // flush takes effect on the pipeline this cycle
  logic               run_flush; // new flush request accepted this cycle

  assign run_flush = (state == RUN) && flush_req;

  // A flush applied in the request cycle redirects to the incoming target.
  assign redirect_pc = run_flush ? flush_pc : target_q;

  // Stage enables, bubble clears and redirect from current state and inputs.
  always_comb begin
    // NOTE: every output gets a default before any branch so no path can
    // leave one unassigned, which would otherwise infer a latch.
    en_pc          = 1'b1;
    en_id          = 1'b1;
    en_ex          = 1'b1;
    en_mm          = 1'b1;
    en_wb          = 1'b1;
    clr_id         = 1'b0;
    clr_ex         = 1'b0;
    clr_mm         = 1'b0;
    clr_wb         = 1'b0;
    redirect_valid = 1'b0;
    apply          = 1'b0;

    if (rst) begin
      en_pc  = 1'b0;
      en_id  = 1'b0;
      en_ex  = 1'b0;
      en_mm  = 1'b0;
      en_wb  = 1'b0;
      clr_id = 1'b1;
      clr_ex = 1'b1;
      clr_mm = 1'b1;
      clr_wb = 1'b1;
    end else begin
      unique case (state)
        RUN, FLUSH_WAIT: begin
          if ((state == FLUSH_WAIT || flush_req) && !mm_busy) begin
            apply = 1'b1;
          end else if (mm_busy) begin
            // Oldest stage wins: freeze PC..MM, bubble into WB.
            en_pc  = 1'b0;
            en_id  = 1'b0;
            en_ex  = 1'b0;
            en_mm  = 1'b0;
            clr_wb = 1'b1;
          end else if (ex_busy) begin
            en_pc  = 1'b0;
            en_id  = 1'b0;
            en_ex  = 1'b0;
            clr_mm = 1'b1;
          end else if (stall_id) begin
            en_pc  = 1'b0;
            en_id  = 1'b0;
            clr_ex = 1'b1;
          end else if (if_busy) begin
            en_pc  = 1'b0;
            clr_id = 1'b1;
          end
        end
        DISCARD: begin
          // The fetch returning here belongs to the squashed path.
          clr_id         = 1'b1;
          clr_ex         = 1'b1;
          en_pc          = !if_busy;
          redirect_valid = !if_busy;
        end
        default: begin
          en_pc = 1'b0;
        end
      endcase

      if (apply) begin
        // Younger stages become bubbles; the MM instruction retires to WB.
        clr_id         = 1'b1;
        clr_ex         = 1'b1;
        clr_mm         = 1'b1;
        en_pc          = !if_busy;
        redirect_valid = !if_busy;
      end
    end
  end

  // FSM state, latched redirect target and saturating performance counters.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state      <= RUN;
      target_q   <= '0;
      perf_stall <= '0;
      perf_flush <= '0;
    end else begin
      if (!en_pc && perf_stall != 32'hFFFF_FFFF) begin
        perf_stall <= perf_stall + 32'd1;
      end
      if (apply && perf_flush != 16'hFFFF) begin
        perf_flush <= perf_flush + 16'd1;
      end
      if (run_flush) begin
        target_q <= flush_pc;
      end

      unique case (state)
        RUN: begin
          if (flush_req) begin
            if (mm_busy)      state <= FLUSH_WAIT;
            else if (if_busy) state <= DISCARD;
          end
        end
        FLUSH_WAIT: begin
          if (!mm_busy) state <= if_busy ? DISCARD : RUN;
        end
        DISCARD: begin
          if (!if_busy) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
